// File: rtl/rijndael_pkg.sv
// Shared types, constants and GF(2^8) helpers for the Rijndael key expander.
package rijndael_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    KEXP_IDLE,
    KEXP_RUN
  } kexp_state_t;

  localparam logic [7:0] RCON_RST = 8'h01;

  // Only 4, 6 and 8 word keys/blocks exist in Rijndael.
  function automatic bit is_legal_len(input int n);
    return (n == 4) || (n == 6) || (n == 8);
  endfunction

  function automatic int nr(input int nk, input int nb);
    return ((nk > nb) ? nk : nb) + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, which also maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r = 8'h01;
    base = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/rijndael_keyschedulestep.sv
// One combinational key-schedule step: derives the next NK words from the previous NK words.
module rijndael_keyschedulestep
  import rijndael_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [32*NK-1:0] key_state,
  input  logic [7:0]       rcon,
  output logic [32*NK-1:0] next_state
);

  word_t prev_w [NK];
  word_t new_w  [NK];

  // Chain the XORs word by word; 8-word keys get an extra SubWord in the middle of the step.
  always_comb begin
    for (int j = 0; j < NK; j++) prev_w[j] = key_state[32*(NK-1-j) +: 32];
    new_w[0] = prev_w[0] ^ sub_word(rot_word(prev_w[NK-1])) ^ {rcon, 24'h000000};
    for (int j = 1; j < NK; j++) begin
      if ((NK == 8) && (j == 4)) new_w[j] = prev_w[j] ^ sub_word(new_w[j-1]);
      else                       new_w[j] = prev_w[j] ^ new_w[j-1];
    end
    next_state = '0;
    for (int j = 0; j < NK; j++) next_state[32*(NK-1-j) +: 32] = new_w[j];
  end

endmodule

// File: rtl/rijndael_keyexpander.sv
// Sequential Rijndael key expander: one schedule step per cycle into a word buffer,
// drained NB words at a time as round keys over valid/ready.
// Optional build macro: RIJNDAEL_KEYEXP_ZEROIZE_EN clears key material after the last round key.
module rijndael_keyexpander
  import rijndael_pkg::*;
#(
  parameter int NK = 4,
  parameter int NB = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [32*NK-1:0] key_i,
  output logic             busy_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic [32*NB-1:0] rk_o,
  output logic [3:0]       rk_idx_o,
  output logic             rk_last_o
);

  localparam int NR     = nr(NK, NB);
  localparam int NW     = NB * (NR + 1);
  localparam int CAP    = NB + NK;
  localparam int NSTEP  = (NW + NK - 1) / NK - 1;
  localparam int LAST_N = NW - NK * NSTEP;
  localparam int CW     = $clog2(CAP + 1);
  localparam int SW     = $clog2(NSTEP + 1);

  localparam logic [CW-1:0] NB_C       = CW'(NB);
  localparam logic [CW-1:0] NK_C       = CW'(NK);
  localparam logic [CW-1:0] LAST_N_C   = CW'(LAST_N);
  localparam logic [CW:0]   CAP_C      = (CW+1)'(CAP);
  localparam logic [SW-1:0] NSTEP_C    = SW'(NSTEP);
  localparam logic [SW-1:0] LASTSTEP_C = SW'(NSTEP - 1);
  localparam logic [3:0]    NR_C       = 4'(NR);

  if (!is_legal_len(NK) || !is_legal_len(NB)) begin : g_bad_len
    $error("rijndael_keyexpander: NK and NB must each be 4, 6 or 8");
  end

  kexp_state_t     state_q, state_d;
  logic [32*NK-1:0] key_q;
  logic [7:0]       rcon_q;
  word_t            buf_q [CAP];
  word_t            buf_d [CAP];
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    steps_q;
  logic [3:0]       idx_q;

  logic [32*NK-1:0] step_out;
  word_t            step_word [NK];
  logic [32*NB-1:0] rk_head;
  logic             do_start, do_step, do_pop, rk_valid, is_last;
  logic [CW-1:0]    append_n, base;

  rijndael_keyschedulestep #(.NK(NK)) u_step (
    .key_state  (key_q),
    .rcon       (rcon_q),
    .next_state (step_out)
  );

  // Step/pop decisions; a step is judged on the pre-pop count so it never overruns the buffer.
  always_comb begin
    do_start = (state_q == KEXP_IDLE) && start_i;
    rk_valid = (state_q == KEXP_RUN) && (count_q >= NB_C);
    do_pop   = rk_valid && rk_ready_i;
    is_last  = rk_valid && (idx_q == NR_C);
    do_step  = (state_q == KEXP_RUN) && (steps_q < NSTEP_C) &&
               (({1'b0, count_q} + {1'b0, NK_C}) <= CAP_C);
    append_n = (steps_q == LASTSTEP_C) ? LAST_N_C : NK_C;
    count_d  = count_q + (do_step ? append_n : '0) - (do_pop ? NB_C : '0);
    for (int j = 0; j < NK; j++) step_word[j] = step_out[32*(NK-1-j) +: 32];
  end

  // Next buffer contents: shift the head out on a pop, then append new words behind what remains.
  always_comb begin
    buf_d = buf_q;
    base  = count_q;
    if (do_pop) begin
      base = count_q - NB_C;
      for (int i = 0; i < CAP - NB; i++) buf_d[i] = buf_q[i+NB];
      for (int i = CAP - NB; i < CAP; i++) buf_d[i] = '0;
    end
    if (do_step) begin
      for (int i = 0; i < CAP; i++) begin
        for (int j = 0; j < NK; j++) begin
          if ((j < int'(append_n)) && ((int'(base) + j) == i)) buf_d[i] = step_word[j];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= KEXP_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and status outputs; the round key itself comes straight from the buffer head.
  always_comb begin
    state_d    = state_q;
    busy_o     = (state_q == KEXP_RUN);
    rk_valid_o = rk_valid;
    rk_last_o  = is_last;
    rk_idx_o   = idx_q;
    case (state_q)
      KEXP_IDLE: if (do_start) state_d = KEXP_RUN;
      KEXP_RUN:  if (do_pop && is_last) state_d = KEXP_IDLE;
      default:   state_d = KEXP_IDLE;
    endcase
    rk_head = '0;
    for (int i = 0; i < NB; i++) rk_head[32*(NB-1-i) +: 32] = buf_q[i];
`ifdef RIJNDAEL_KEYEXP_ZEROIZE_EN
    rk_o = rk_valid ? rk_head : '0;
`else
    rk_o = rk_head;
`endif
  end

  // Datapath registers: load on start, then step/pop while running.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q   <= '0;
      rcon_q  <= RCON_RST;
      count_q <= '0;
      steps_q <= '0;
      idx_q   <= '0;
      for (int i = 0; i < CAP; i++) buf_q[i] <= '0;
    end else if (do_start) begin
      key_q   <= key_i;
      rcon_q  <= RCON_RST;
      count_q <= NK_C;
      steps_q <= '0;
      idx_q   <= '0;
      for (int i = 0; i < NK; i++) buf_q[i] <= key_i[32*(NK-1-i) +: 32];
    end else if (state_q == KEXP_RUN) begin
      if (do_step) begin
        key_q   <= step_out;
        rcon_q  <= xtime(rcon_q);
        steps_q <= steps_q + 1'b1;
      end
      buf_q   <= buf_d;
      count_q <= count_d;
      if (do_pop && !is_last) idx_q <= idx_q + 4'd1;
`ifdef RIJNDAEL_KEYEXP_ZEROIZE_EN
      if (do_pop && is_last) begin
        key_q <= '0;
        for (int i = 0; i < CAP; i++) buf_q[i] <= '0;
      end
`endif
    end
  end

endmodule
